hub75_scan_ctrl: RTL and testbench

Parametrised successor to the HUB75 main scan FSM. It sequences binary-coded-modulation (BCM) display slots for any row count and bit depth, and drives blank/lat/row-select. It also pipelines fetchshift requests, so the next line shifts while the current line is lit. New capabilities over the current FSM:
- global brightness scaling of lit time;
- selectable row-select mode (shift register or parallel address);
- enable/stop control.

---
 rtl/hub75_pkg.sv | 26 ++
 rtl/hub75_bcm_timer.sv | 56 +++++
 rtl/hub75_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_BLANK,
    ST_LATCH,
    ST_ROWSEL,
    ST_DISP
  } scan_state_t;

  localparam int ADDR_MODE_SHIFT    = 0;
  localparam int ADDR_MODE_PARALLEL = 1;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the slot counter: the longest slot is BLANK_BASE << (BITS-1).
  function automatic int count_width(input int base, input int bits);
    return $clog2(base) + bits;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM slot timer: loads one bit plane's on-time and brightness-scaled lit
// time, then counts both down so the scan FSM can gate blank and slot end.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int BLANK_BASE = 16,
  localparam int BW        = width_of(BITS),
  localparam int CW        = count_width(BLANK_BASE, BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [BW-1:0] bit_sel,
  input  logic [7:0]    brightness,
  output logic          lit_active,
  output logic          done
);

  localparam int PW = CW + 8;

  logic [CW-1:0] on_time;
  logic [PW-1:0] product;
  logic [CW-1:0] lit;
  logic [CW-1:0] remain;
  logic [CW-1:0] lit_remain;

  // brightness+1 is 1..256, so the product shifted down by 8 never exceeds
  // on_time and brightness=255 yields exactly on_time.
  assign on_time = CW'(BLANK_BASE) << bit_sel;
  assign product = PW'(on_time) * PW'({1'b0, brightness} + 9'd1);
  assign lit     = CW'(product >> 8);

  // Load both counters at slot entry, then count each down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain     <= '0;
      lit_remain <= '0;
    end else if (load) begin
      remain     <= on_time;
      lit_remain <= lit;
    end else begin
      if (remain != '0) begin
        remain <= remain - 1'b1;
      end
      if (lit_remain != '0) begin
        lit_remain <= lit_remain - 1'b1;
      end
    end
  end

  // The first slot cycle sees remain=on_time, so remain<=1 marks its last cycle.
  assign lit_active = (lit_remain != '0);
  assign done       = (remain <= CW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: sequences BCM slots over all rows and bit planes,
// drives blank/lat/row select and overlaps the next line's shift with the
// currently lit line.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int BITS       = 8,
  parameter int ADDR_MODE  = 0,
  parameter int BLANK_BASE = 16,
  parameter int LAT_CYCLES = 2,
  localparam int BW        = width_of(BITS),
  localparam int RW        = $clog2(ROWS)
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    brightness,
  input  logic          fetchshift_busy,
  output logic          fetchshift_start,
  output logic [BW-1:0] bit_out,
  output logic [RW-1:0] row_out,
  output logic          frame_start,
  output logic          lat,
  output logic          blank,
  output logic          row_clk,
  output logic          row_data,
  output logic [RW-1:0] row_addr
);

  localparam int SW = $clog2(LAT_CYCLES + 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_t   state;
  scan_state_t   state_next;
  logic [SW-1:0] sub_cnt;
  logic [BW-1:0] disp_bit;
  logic [RW-1:0] disp_row;
  logic [BW-1:0] next_bit;
  logic [RW-1:0] next_row;
  logic          pending;
  logic [1:0]    guard;
  logic          shift_complete;
  logic          issue_first;
  logic          issue_next;
  logic          load;
  logic          lit_active;
  logic          done;
  logic [BW-1:0] timer_bit;

  // Successor of the pending line: bits run fastest, then rows, both wrap.
  always_comb begin
    next_bit = bit_out + 1'b1;
    next_row = row_out;
    if (bit_out == LAST_BIT) begin
      next_bit = '0;
      next_row = (row_out == LAST_ROW) ? '0 : row_out + 1'b1;
    end
  end

  // The fetchshift block gets two cycles (pulse and the one after) to raise
  // busy; only after that does a low busy mean the shift has finished.
  assign shift_complete = !pending || ((guard == 2'd0) && !fetchshift_busy);

  // Next-state and panel-control decode for the scan sequence.
  always_comb begin
    state_next  = state;
    issue_first = 1'b0;
    issue_next  = 1'b0;
    load        = 1'b0;
    blank       = 1'b1;
    lat         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          issue_first = 1'b1;
          state_next  = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (shift_complete) begin
          state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        lat = 1'b1;
        if (sub_cnt == SW'(LAT_CYCLES - 1)) begin
          if (bit_out == '0) begin
            state_next = ST_ROWSEL;
          end else begin
            state_next = ST_DISP;
            load       = 1'b1;
            issue_next = 1'b1;
          end
        end
      end
      ST_ROWSEL: begin
        if (sub_cnt == SW'(1)) begin
          state_next = ST_DISP;
          load       = 1'b1;
          issue_next = 1'b1;
        end
      end
      ST_DISP: begin
        blank = !lit_active;
        if (done && shift_complete) begin
          state_next = enable ? ST_BLANK : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register with a per-state cycle counter for LATCH and ROWSEL.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sub_cnt <= '0;
    end else begin
      state   <= state_next;
      sub_cnt <= (state_next != state) ? '0 : sub_cnt + 1'b1;
    end
  end

  // Pending line, shift request pulses and the busy handshake tracker.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bit_out          <= '0;
      row_out          <= '0;
      fetchshift_start <= 1'b0;
      frame_start      <= 1'b0;
      pending          <= 1'b0;
      guard            <= 2'd0;
    end else begin
      fetchshift_start <= issue_first || issue_next;
      frame_start      <= 1'b0;
      if (issue_first) begin
        bit_out     <= '0;
        row_out     <= '0;
        frame_start <= 1'b1;
      end else if (issue_next) begin
        bit_out     <= next_bit;
        row_out     <= next_row;
        frame_start <= (next_bit == '0) && (next_row == '0);
      end
      if (issue_first || issue_next) begin
        pending <= 1'b1;
        guard   <= 2'd2;
      end else begin
        if (guard != 2'd0) begin
          guard <= guard - 2'd1;
        end
        if ((guard == 2'd0) && !fetchshift_busy) begin
          pending <= 1'b0;
        end
      end
    end
  end

  // Displayed line follows the pending line while latching; the parallel
  // row address is captured in the first row-select cycle and then held.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      disp_bit <= '0;
      disp_row <= '0;
      row_addr <= '0;
    end else begin
      if (state == ST_LATCH) begin
        disp_bit <= bit_out;
        disp_row <= row_out;
      end
      if ((ADDR_MODE == ADDR_MODE_PARALLEL) && (state == ST_ROWSEL) && (sub_cnt == '0)) begin
        row_addr <= disp_row;
      end
    end
  end

  // Shift-register row select: one clock per row, a 1 injected for row 0.
  assign row_clk  = (ADDR_MODE == ADDR_MODE_SHIFT) && (state == ST_ROWSEL) && (sub_cnt == '0);
  assign row_data = row_clk && (disp_row == '0);

  // While latching, disp is only just being updated, so take the pending bit.
  assign timer_bit = (state == ST_LATCH) ? bit_out : disp_bit;

  hub75_bcm_timer #(
    .BITS       (BITS),
    .BLANK_BASE (BLANK_BASE)
  ) u_timer (
    .clk        (sys_clk),
    .rst        (rst),
    .load       (load),
    .bit_sel    (timer_bit),
    .brightness (brightness),
    .lit_active (lit_active),
    .done       (done)
  );

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: two instances (shift-register and parallel row
// select) with ROWS=4, BITS=2, BLANK_BASE=4, LAT_CYCLES=2, a fetchshift busy
// model and a negedge monitor that logs starts, blank/lat runs and row select.
module tb_hub75_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] brightness;
  logic       busy;

  logic       start0, frame0, lat0, blank0, rclk0, rdata0;
  logic [0:0] bit0;
  logic [1:0] row0, addr0;
  logic       start1, frame1, lat1, blank1, rclk1, rdata1;
  logic [0:0] bit1;
  logic [1:0] row1, addr1;

  int tests_run    = 0;
  int tests_failed = 0;

  int busy_len   = 3;
  int busy_cnt   = 0;
  bit start_last = 1'b0;

  int st_bit[$], st_row[$], st_frame[$], st_addr1[$];
  int low_runs[$], lat_runs[$], lat_rise_busy[$], lat_rise_gap[$], rdata_pulses[$];
  int low_len, lat_len, total_low, since_start;
  int stray_rdata0, stray_rsel1, stray_addr0;
  bit prev_lat, prev_rclk;

  hub75_scan_ctrl #(
    .ROWS(4), .BITS(2), .ADDR_MODE(0), .BLANK_BASE(4), .LAT_CYCLES(2)
  ) dut0 (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .brightness(brightness),
    .fetchshift_busy(busy), .fetchshift_start(start0), .bit_out(bit0),
    .row_out(row0), .frame_start(frame0), .lat(lat0), .blank(blank0),
    .row_clk(rclk0), .row_data(rdata0), .row_addr(addr0)
  );

  hub75_scan_ctrl #(
    .ROWS(4), .BITS(2), .ADDR_MODE(1), .BLANK_BASE(4), .LAT_CYCLES(2)
  ) dut1 (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .brightness(brightness),
    .fetchshift_busy(busy), .fetchshift_start(start1), .bit_out(bit1),
    .row_out(row1), .frame_start(frame1), .lat(lat1), .blank(blank1),
    .row_clk(rclk1), .row_data(rdata1), .row_addr(addr1)
  );

  always #5 sys_clk = ~sys_clk;

  // Fetchshift model: busy rises the cycle after a start and stays high busy_len cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (start_last) busy_cnt = busy_len;
      start_last = start0;
      busy = (busy_cnt > 0);
    end
  end

  // Monitor: log what both instances do, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (start0) begin
      st_bit.push_back(int'(bit0));
      st_row.push_back(int'(row0));
      st_frame.push_back(int'(frame0));
      since_start = 0;
    end else begin
      since_start++;
    end
    if (start1) st_addr1.push_back(int'(addr1));
    if (!blank0) begin
      low_len++;
      total_low++;
    end else if (low_len > 0) begin
      low_runs.push_back(low_len);
      low_len = 0;
    end
    if (lat0) begin
      if (!prev_lat) begin
        lat_rise_busy.push_back(int'(busy));
        lat_rise_gap.push_back(since_start);
      end
      lat_len++;
    end else if (lat_len > 0) begin
      lat_runs.push_back(lat_len);
      lat_len = 0;
    end
    prev_lat = lat0;
    if (rclk0 && !prev_rclk) rdata_pulses.push_back(int'(rdata0));
    if (rdata0 && !rclk0) stray_rdata0++;
    prev_rclk = rclk0;
    if (rclk1 || rdata1) stray_rsel1++;
    if (addr0 != 2'd0) stray_addr0++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    st_bit.delete(); st_row.delete(); st_frame.delete(); st_addr1.delete();
    low_runs.delete(); lat_runs.delete(); lat_rise_busy.delete();
    lat_rise_gap.delete(); rdata_pulses.delete();
    low_len = 0; lat_len = 0; total_low = 0; since_start = 0;
    stray_rdata0 = 0; stray_rsel1 = 0; stray_addr0 = 0;
    prev_lat = 1'b0; prev_rclk = 1'b0;
    busy_cnt = 0; start_last = 1'b0;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_blank"}, blank0, 1);
    checkOutput({pfx, "_lat"}, lat0, 0);
    checkOutput({pfx, "_start"}, start0, 0);
    checkOutput({pfx, "_frame"}, frame0, 0);
    checkOutput({pfx, "_rowclk"}, rclk0, 0);
    checkOutput({pfx, "_rowdata"}, rdata0, 0);
    checkOutput({pfx, "_bit"}, bit0, 0);
    checkOutput({pfx, "_row"}, row0, 0);
    checkOutput({pfx, "_rowaddr"}, addr1, 0);
    checkOutput({pfx, "_blank_p"}, blank1, 1);
  endtask

  // Reset both instances, clear the log, then start scanning.
  task automatic applyStimulus(input int bri, input int blen);
    rst = 1'b1;
    enable = 1'b0;
    brightness = bri[7:0];
    busy_len = blen;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    clearLog();
    @(negedge sys_clk);
    rst = 1'b0;
    enable = 1'b1;
  endtask

  task automatic waitStarts(input int n, input int budget);
    int c = 0;
    while (st_bit.size() < n && c < budget) begin
      @(posedge sys_clk);
      c++;
    end
    if (st_bit.size() < n) checkOutput("start_timeout", st_bit.size(), n);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int n_drop;
    rst = 1'b1;
    enable = 1'b0;
    brightness = 8'd255;

    // Power-on reset
    repeat (3) @(negedge sys_clk);
    checkResetState("por");

    // Full brightness, short shifts: ordering, slot lengths, row select
    applyStimulus(255, 3);
    waitStarts(17, 2000);
    for (int i = 0; i < 17; i++) begin
      checkOutput($sformatf("start_bit[%0d]", i), st_bit[i], i % 2);
      checkOutput($sformatf("start_row[%0d]", i), st_row[i], (i / 2) % 4);
      checkOutput($sformatf("frame[%0d]", i), st_frame[i], (i % 8 == 0) ? 1 : 0);
      checkOutput($sformatf("rowaddr[%0d]", i), st_addr1[i], (i == 0) ? 0 : ((i - 1) / 2) % 4);
    end
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("lit_b255[%0d]", k), low_runs[k], (k % 2 == 1) ? 8 : 4);
      checkOutput($sformatf("lat_len[%0d]", k), lat_runs[k], 2);
    end
    checkOutput("rowclk_pulses", rdata_pulses.size(), 8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rowdata[%0d]", k), rdata_pulses[k], (k % 4 == 0) ? 1 : 0);
    end
    checkOutput("stray_rowdata", stray_rdata0, 0);
    checkOutput("parallel_rowclk", stray_rsel1, 0);
    checkOutput("shift_rowaddr", stray_addr0, 0);

    // Reset asserted mid-DISP
    c = 0;
    while (blank0 && c < 200) begin
      @(negedge sys_clk);
      c++;
    end
    checkOutput("reached_disp", blank0, 0);
    rst = 1'b1;
    @(negedge sys_clk);
    checkResetState("mid");
    repeat (2) @(negedge sys_clk);

    // Half brightness
    applyStimulus(127, 3);
    waitStarts(9, 1000);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("lit_b127[%0d]", k), low_runs[k], (k % 2 == 1) ? 4 : 2);
    end

    // Zero brightness: panel stays dark while scanning continues
    applyStimulus(0, 3);
    waitStarts(9, 1000);
    checkOutput("lit_b0_total", total_low, 0);
    checkOutput("lat_b0", lat_runs[0], 2);

    // Slow fetchshift stretches slots; lat waits for busy to fall
    applyStimulus(255, 20);
    waitStarts(5, 2000);
    checkOutput("slow_lat_rises", lat_rise_busy.size(), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("slow_lat_busy[%0d]", k), lat_rise_busy[k], 0);
      checkOutput($sformatf("slow_gap_ge21[%0d]", k), (lat_rise_gap[k] >= 21) ? 1 : 0, 1);
    end
    checkOutput("slow_lit0", low_runs[0], 4);
    checkOutput("slow_lit1", low_runs[1], 8);

    // Drop enable during the (1,2) slot, then re-enable
    applyStimulus(255, 3);
    c = 0;
    while (!(st_bit.size() > 0 && st_bit[st_bit.size() - 1] == 0 &&
             st_row[st_bit.size() - 1] == 3) && c < 1000) begin
      @(posedge sys_clk);
      c++;
    end
    checkOutput("saw_start_0_3", st_bit.size(), 7);
    @(negedge sys_clk);
    enable = 1'b0;
    n_drop = st_bit.size();
    repeat (40) @(negedge sys_clk);
    checkOutput("stop_no_start", st_bit.size(), n_drop);
    checkOutput("stop_blank", blank0, 1);
    checkOutput("stop_slots_done", low_runs.size(), 6);
    checkOutput("stop_last_lit", low_runs[low_runs.size() - 1], 8);
    checkOutput("stop_lat_count", lat_runs.size(), 6);
    enable = 1'b1;
    waitStarts(n_drop + 1, 200);
    checkOutput("restart_bit", st_bit[n_drop], 0);
    checkOutput("restart_row", st_row[n_drop], 0);
    checkOutput("restart_frame", st_frame[n_drop], 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
